// File: rtl/fetch_stage.sv
// fetch_stage: IF stage with PC register, redirect/squash and IF/ID reg.
// Optional stall/flush counters built only with FETCH_PERF_COUNTERS_EN.
//
// Ports:
//   Clock, Reset          rising-edge clock, async active-high reset
//   PCWriteEnable         0 holds PC (hazard stall)
//   IFIDWriteEnable       0 holds IF/ID register
//   BranchTaken/Target    branch redirect from ID (wins over jump)
//   Jump/JumpTarget       jump redirect from ID
//   IMemData/IMemAddr     instruction memory, combinational read at PC
//   IFIDInstruction       registered instruction to ID
//   IFIDPCPlus4           registered PC+4 of that instruction
//   IFIDValid             0 marks a bubble
//   StallCount/FlushCount saturating perf counters (0 when disabled)

module fetch_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        Clock,
  input  logic        Reset,
  input  logic        PCWriteEnable,
  input  logic        IFIDWriteEnable,
  input  logic        BranchTaken,
  input  logic [31:0] BranchTarget,
  input  logic        Jump,
  input  logic [31:0] JumpTarget,
  input  logic [31:0] IMemData,
  output logic [31:0] IMemAddr,
  output logic [31:0] IFIDInstruction,
  output logic [31:0] IFIDPCPlus4,
  output logic        IFIDValid,
  output logic [15:0] StallCount,
  output logic [15:0] FlushCount
);

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc4;
    logic        valid;
  } if_id_t;

  logic [31:0] pc;
  logic [31:0] pc4;
  logic [31:0] target;
  logic        redirect;
  logic        kill;
  if_id_t      ifid;

  assign pc4      = pc + 32'd4;
  assign redirect = BranchTaken | Jump;
  // Redirects during a PC stall are dropped; ID re-presents them.
  assign kill     = redirect & PCWriteEnable;

  always_comb begin
    target = BranchTaken ? BranchTarget : JumpTarget;
    target = target & ~32'h3;
  end

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      pc <= RESET_PC;
    end else if (kill) begin
      pc <= target;
    end else if (PCWriteEnable) begin
      pc <= pc4;
    end
  end

  // Squash beats hold: a kill bubbles IF/ID even while ID is stalled.
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      ifid <= '0;
    end else if (kill) begin
      ifid <= '0;
    end else if (IFIDWriteEnable) begin
      ifid <= '{instr: IMemData, pc4: pc4, valid: 1'b1};
    end
  end

  assign IMemAddr        = pc;
  assign IFIDInstruction = ifid.instr;
  assign IFIDPCPlus4     = ifid.pc4;
  assign IFIDValid       = ifid.valid;

`ifdef FETCH_PERF_COUNTERS_EN
  logic [15:0] stall_q;
  logic [15:0] flush_q;

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      stall_q <= '0;
      flush_q <= '0;
    end else begin
      if (!PCWriteEnable && stall_q != 16'hFFFF)
        stall_q <= stall_q + 16'd1;
      if (kill && flush_q != 16'hFFFF)
        flush_q <= flush_q + 16'd1;
    end
  end

  assign StallCount = stall_q;
  assign FlushCount = flush_q;
`else
  assign StallCount = 16'h0000;
  assign FlushCount = 16'h0000;
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// tb_fetch_stage: directed bench for fetch_stage.
// Counter expectations follow FETCH_PERF_COUNTERS_EN.

module tb_fetch_stage;

`ifdef FETCH_PERF_COUNTERS_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif

  logic        Clock = 1'b0;
  logic        Reset;
  logic        PCWriteEnable;
  logic        IFIDWriteEnable;
  logic        BranchTaken;
  logic [31:0] BranchTarget;
  logic        Jump;
  logic [31:0] JumpTarget;
  logic [31:0] IMemData;
  logic [31:0] IMemAddr;
  logic [31:0] IFIDInstruction;
  logic [31:0] IFIDPCPlus4;
  logic        IFIDValid;
  logic [15:0] StallCount;
  logic [15:0] FlushCount;

  int checks = 0;
  int errors = 0;
  logic [15:0] exp_stall = 16'h0;
  logic [15:0] exp_flush = 16'h0;

  fetch_stage #(.RESET_PC(32'h0000_0000)) dut (
    .Clock(Clock),
    .Reset(Reset),
    .PCWriteEnable(PCWriteEnable),
    .IFIDWriteEnable(IFIDWriteEnable),
    .BranchTaken(BranchTaken),
    .BranchTarget(BranchTarget),
    .Jump(Jump),
    .JumpTarget(JumpTarget),
    .IMemData(IMemData),
    .IMemAddr(IMemAddr),
    .IFIDInstruction(IFIDInstruction),
    .IFIDPCPlus4(IFIDPCPlus4),
    .IFIDValid(IFIDValid),
    .StallCount(StallCount),
    .FlushCount(FlushCount)
  );

  always #5 Clock = ~Clock;

  task automatic step(input int n);
    repeat (n) @(negedge Clock);
  endtask

  task automatic idle_inputs();
    PCWriteEnable   = 1'b1;
    IFIDWriteEnable = 1'b1;
    BranchTaken     = 1'b0;
    BranchTarget    = 32'h0;
    Jump            = 1'b0;
    JumpTarget      = 32'h0;
    IMemData        = 32'h0;
  endtask

  task automatic test_reset();
    idle_inputs();
    Reset = 1'b1;
    #1;
    checks++;
    if (IMemAddr !== 32'h0) begin
      errors++;
      $display("FAIL rst_pc got %h exp %h", IMemAddr, 32'h0);
    end
    checks++;
    if (IFIDValid !== 1'b0) begin
      errors++;
      $display("FAIL rst_valid got %b exp 0", IFIDValid);
    end
    checks++;
    if (IFIDInstruction !== 32'h0) begin
      errors++;
      $display("FAIL rst_instr got %h exp 0", IFIDInstruction);
    end
    checks++;
    if (StallCount !== 16'h0 || FlushCount !== 16'h0) begin
      errors++;
      $display("FAIL rst_cnt got %h/%h exp 0/0",
               StallCount, FlushCount);
    end
    // inputs are ignored while reset is held across edges
    BranchTaken  = 1'b1;
    BranchTarget = 32'h40;
    step(2);
    checks++;
    if (IMemAddr !== 32'h0) begin
      errors++;
      $display("FAIL rst_hold_pc got %h exp 0", IMemAddr);
    end
    idle_inputs();
    Reset = 1'b0;
    exp_stall = 16'h0;
    exp_flush = 16'h0;
  endtask

  task automatic test_sequential();
    IMemData = 32'h8C08_0004;
    step(3);
    checks++;
    if (IMemAddr !== 32'hC) begin
      errors++;
      $display("FAIL seq_pc got %h exp %h", IMemAddr, 32'hC);
    end
    checks++;
    if (IFIDInstruction !== 32'h8C08_0004) begin
      errors++;
      $display("FAIL seq_instr got %h exp 8c080004",
               IFIDInstruction);
    end
    checks++;
    if (IFIDPCPlus4 !== 32'hC || IFIDValid !== 1'b1) begin
      errors++;
      $display("FAIL seq_pc4 got %h/%b exp 0000000c/1",
               IFIDPCPlus4, IFIDValid);
    end
  endtask

  task automatic test_stall();
    IMemData = 32'h1111_1111;
    step(1);
    PCWriteEnable   = 1'b0;
    IFIDWriteEnable = 1'b0;
    BranchTaken     = 1'b1;
    BranchTarget    = 32'h80;
    IMemData        = 32'hDEAD_BEEF;
    step(2);
    if (PERF) exp_stall = exp_stall + 16'd2;
    checks++;
    if (IMemAddr !== 32'h10) begin
      errors++;
      $display("FAIL stall_pc got %h exp 00000010", IMemAddr);
    end
    checks++;
    if (IFIDInstruction !== 32'h1111_1111 ||
        IFIDPCPlus4 !== 32'h10 || IFIDValid !== 1'b1) begin
      errors++;
      $display("FAIL stall_ifid got %h/%h/%b exp 11111111/10/1",
               IFIDInstruction, IFIDPCPlus4, IFIDValid);
    end
    checks++;
    if (StallCount !== exp_stall || FlushCount !== exp_flush) begin
      errors++;
      $display("FAIL stall_cnt got %h/%h exp %h/%h",
               StallCount, FlushCount, exp_stall, exp_flush);
    end
    idle_inputs();
  endtask

  task automatic test_redirect();
    IMemData = 32'h2222_2222;
    step(2);
    checks++;
    if (IMemAddr !== 32'h18 || IFIDPCPlus4 !== 32'h18) begin
      errors++;
      $display("FAIL pre_br got %h/%h exp 18/18",
               IMemAddr, IFIDPCPlus4);
    end
    BranchTaken  = 1'b1;
    BranchTarget = 32'h43;
    Jump         = 1'b1;
    JumpTarget   = 32'h100;
    step(1);
    if (PERF) exp_flush = exp_flush + 16'd1;
    checks++;
    if (IMemAddr !== 32'h40) begin
      errors++;
      $display("FAIL br_pc got %h exp 00000040", IMemAddr);
    end
    checks++;
    if (IFIDValid !== 1'b0 || IFIDInstruction !== 32'h0 ||
        IFIDPCPlus4 !== 32'h0) begin
      errors++;
      $display("FAIL br_bubble got %b/%h/%h exp 0/0/0",
               IFIDValid, IFIDInstruction, IFIDPCPlus4);
    end
    checks++;
    if (FlushCount !== exp_flush) begin
      errors++;
      $display("FAIL br_flush got %h exp %h", FlushCount, exp_flush);
    end
    idle_inputs();
    IMemData = 32'h3333_3333;
    step(1);
    checks++;
    if (IMemAddr !== 32'h44 || IFIDInstruction !== 32'h3333_3333 ||
        IFIDPCPlus4 !== 32'h44 || IFIDValid !== 1'b1) begin
      errors++;
      $display("FAIL br_after got %h/%h/%h/%b exp 44/33333333/44/1",
               IMemAddr, IFIDInstruction, IFIDPCPlus4, IFIDValid);
    end
  endtask

  task automatic test_kill_hold();
    IFIDWriteEnable = 1'b0;
    Jump            = 1'b1;
    JumpTarget      = 32'h200;
    IMemData        = 32'h4444_4444;
    step(1);
    if (PERF) exp_flush = exp_flush + 16'd1;
    checks++;
    if (IMemAddr !== 32'h200 || IFIDValid !== 1'b0 ||
        IFIDInstruction !== 32'h0) begin
      errors++;
      $display("FAIL kill_hold got %h/%b/%h exp 200/0/0",
               IMemAddr, IFIDValid, IFIDInstruction);
    end
    Jump = 1'b0;
    step(1);
    checks++;
    if (IMemAddr !== 32'h204 || IFIDValid !== 1'b0 ||
        IFIDInstruction !== 32'h0) begin
      errors++;
      $display("FAIL drop_fetch got %h/%b/%h exp 204/0/0",
               IMemAddr, IFIDValid, IFIDInstruction);
    end
    checks++;
    if (FlushCount !== exp_flush || StallCount !== exp_stall) begin
      errors++;
      $display("FAIL kill_cnt got %h/%h exp %h/%h",
               FlushCount, StallCount, exp_flush, exp_stall);
    end
    idle_inputs();
  endtask

  task automatic test_wrap();
    Jump       = 1'b1;
    JumpTarget = 32'hFFFF_FFFF;
    step(1);
    if (PERF) exp_flush = exp_flush + 16'd1;
    checks++;
    if (IMemAddr !== 32'hFFFF_FFFC) begin
      errors++;
      $display("FAIL wrap_tgt got %h exp fffffffc", IMemAddr);
    end
    Jump     = 1'b0;
    IMemData = 32'h5555_5555;
    step(1);
    checks++;
    if (IMemAddr !== 32'h0 || IFIDPCPlus4 !== 32'h0 ||
        IFIDValid !== 1'b1 || IFIDInstruction !== 32'h5555_5555) begin
      errors++;
      $display("FAIL wrap got %h/%h/%b/%h exp 0/0/1/55555555",
               IMemAddr, IFIDPCPlus4, IFIDValid, IFIDInstruction);
    end
    checks++;
    if (FlushCount !== exp_flush) begin
      errors++;
      $display("FAIL wrap_flush got %h exp %h", FlushCount, exp_flush);
    end
  endtask

  task automatic test_reset_midop();
    BranchTaken  = 1'b1;
    BranchTarget = 32'h300;
    #2;
    Reset = 1'b1;
    #1;
    checks++;
    if (IMemAddr !== 32'h0 || IFIDValid !== 1'b0 ||
        IFIDInstruction !== 32'h0 || IFIDPCPlus4 !== 32'h0) begin
      errors++;
      $display("FAIL mid_rst got %h/%b/%h/%h exp 0/0/0/0",
               IMemAddr, IFIDValid, IFIDInstruction, IFIDPCPlus4);
    end
    checks++;
    if (StallCount !== 16'h0 || FlushCount !== 16'h0) begin
      errors++;
      $display("FAIL mid_rst_cnt got %h/%h exp 0/0",
               StallCount, FlushCount);
    end
    step(2);
    checks++;
    if (IMemAddr !== 32'h0) begin
      errors++;
      $display("FAIL mid_rst_hold got %h exp 0", IMemAddr);
    end
    Reset = 1'b0;
    exp_stall = 16'h0;
    exp_flush = 16'h0;
    idle_inputs();
    IMemData = 32'h6666_6666;
    step(1);
    checks++;
    if (IMemAddr !== 32'h4 || IFIDInstruction !== 32'h6666_6666 ||
        IFIDPCPlus4 !== 32'h4 || IFIDValid !== 1'b1) begin
      errors++;
      $display("FAIL post_rst got %h/%h/%h/%b exp 4/66666666/4/1",
               IMemAddr, IFIDInstruction, IFIDPCPlus4, IFIDValid);
    end
  endtask

  task automatic test_saturation();
    int n;
    logic [15:0] e1;
    logic [15:0] e2;
    n  = PERF ? 65534 : 40;
    e1 = PERF ? 16'hFFFE : 16'h0;
    e2 = PERF ? 16'hFFFF : 16'h0;
    PCWriteEnable = 1'b0;
    step(n);
    checks++;
    if (StallCount !== e1) begin
      errors++;
      $display("FAIL sat_pre got %h exp %h", StallCount, e1);
    end
    step(1);
    checks++;
    if (StallCount !== e2) begin
      errors++;
      $display("FAIL sat_max got %h exp %h", StallCount, e2);
    end
    step(1);
    checks++;
    if (StallCount !== e2) begin
      errors++;
      $display("FAIL sat_hold got %h exp %h", StallCount, e2);
    end
    checks++;
    if (IMemAddr !== 32'h4) begin
      errors++;
      $display("FAIL sat_pc got %h exp 4", IMemAddr);
    end
    #2;
    Reset = 1'b1;
    #1;
    checks++;
    if (StallCount !== 16'h0 || IMemAddr !== 32'h0 ||
        IFIDValid !== 1'b0 || IFIDInstruction !== 32'h0) begin
      errors++;
      $display("FAIL sat_rst got %h/%h/%b/%h exp 0/0/0/0",
               StallCount, IMemAddr, IFIDValid, IFIDInstruction);
    end
    #1;
    Reset = 1'b0;
    idle_inputs();
    step(1);
  endtask

  initial begin
    test_reset();
    test_sequential();
    test_stall();
    test_redirect();
    test_kill_hold();
    test_wrap();
    test_reset_midop();
    test_saturation();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/fetch_stage.md
FETCH_STAGE -- requirements
Module: fetch_stage

Interface
REQ-001 SHALL provide parameter RESET_PC, default 32'h0000_0000, PC value loaded on reset.
REQ-002 SHALL provide port Clock  input  1  sole clock; all state updates on rising edge.
REQ-003 SHALL provide port Reset  input  1  asynchronous, active-high reset.
REQ-004 SHALL provide port PCWriteEnable  input  1  from hazard unit; 0 holds PC.
REQ-005 SHALL provide port IFIDWriteEnable  input  1  from hazard unit; 0 holds IF/ID register.
REQ-006 SHALL provide port BranchTaken  input  1  branch resolved taken in ID.
REQ-007 SHALL provide port BranchTarget  input  32  branch destination.
REQ-008 SHALL provide port Jump  input  1  jump decoded in ID.
REQ-009 SHALL provide port JumpTarget  input  32  jump destination.
REQ-010 SHALL provide port IMemData  input  32  instruction word read at IMemAddr, same cycle.
REQ-011 SHALL provide port IMemAddr  output  32  instruction memory address, equal to current PC.
REQ-012 SHALL provide port IFIDInstruction  output  32  registered instruction to ID stage.
REQ-013 SHALL provide port IFIDPCPlus4  output  32  registered PC+4 of that instruction.
REQ-014 SHALL provide port IFIDValid  output  1  1 = real instruction, 0 = bubble.
REQ-015 SHALL provide port StallCount  output  16  performance counter, stall cycles.
REQ-016 SHALL provide port FlushCount  output  16  performance counter, squashed fetches.

Function
REQ-017 IMemAddr SHALL be combinationally equal to the PC register; zero latency.
REQ-018 Redirect SHALL be defined as BranchTaken OR Jump; target SHALL be BranchTarget when BranchTaken=1, else JumpTarget (branch has priority on simultaneous assertion).
REQ-019 Target bits [1:0] SHALL be forced to 2'b00 before loading PC.
REQ-020 Kill SHALL be defined as Redirect AND PCWriteEnable.
REQ-021 On each rising edge: Kill -> PC <= target; else PCWriteEnable=1 -> PC <= PC+4, modulo 2^32 (0xFFFFFFFC wraps to 0x00000000); else PC holds.
REQ-022 Redirect with PCWriteEnable=0 SHALL be ignored (no PC change, no squash, no count); ID re-presents it after the stall.
REQ-023 On each rising edge IF/ID SHALL update with priority: Kill -> IFIDInstruction=0, IFIDPCPlus4=0, IFIDValid=0; else IFIDWriteEnable=1 -> IFIDInstruction=IMemData, IFIDPCPlus4=PC+4, IFIDValid=1; else all three hold.
REQ-024 Kill SHALL squash IF/ID even when IFIDWriteEnable=0.
REQ-025 Exactly one bubble SHALL be inserted per Kill; fetch from the target begins the following cycle, 1-cycle redirect penalty.
REQ-026 PCWriteEnable=1 with IFIDWriteEnable=0 and no Kill SHALL advance PC while IF/ID holds (fetched word dropped); legal, not flagged.

Reset
REQ-027 Reset=1 SHALL immediately, without a clock edge, set PC=RESET_PC, IFIDInstruction=0, IFIDPCPlus4=0, IFIDValid=0, StallCount=0, FlushCount=0.
REQ-028 While Reset=1 all inputs SHALL be ignored; first fetch after deassertion SHALL use RESET_PC.
REQ-029 Reset asserted mid-stall or mid-redirect SHALL discard the pending operation entirely.

Configuration
REQ-030 Macro FETCH_PERF_COUNTERS_EN defined: StallCount SHALL increment each rising edge with PCWriteEnable=0 and FlushCount each Kill, both saturating at 16'hFFFF.
REQ-031 Macro FETCH_PERF_COUNTERS_EN undefined: StallCount and FlushCount SHALL be constant 0, no counter flops; all other behaviour identical.

Verification
REQ-032 Reset asserted, no clock -> IMemAddr=0x00000000, IFIDValid=0, IFIDInstruction=0x00000000.
REQ-033 Enables=1, IMemData=0x8C080004, 3 edges -> IMemAddr=0x0000000C, IFIDInstruction=0x8C080004, IFIDPCPlus4=0x0000000C, IFIDValid=1.
REQ-034 At PC=0x10, both enables=0 for 2 edges -> PC stays 0x10, IF/ID unchanged, StallCount +2 (macro on); BranchTaken=1 target 0x80 during stall -> ignored.
REQ-035 At PC=0x18, BranchTaken=1, BranchTarget=0x43, Jump=1, JumpTarget=0x100 -> next IMemAddr=0x40, IFIDValid=0, IFIDInstruction=0, FlushCount +1.
REQ-036 Jump to 0xFFFFFFFC, then one normal edge -> IMemAddr=0x00000000, IFIDPCPlus4=0x00000000, IFIDValid=1.
REQ-037 Force StallCount to 0xFFFF via 65535 stall cycles, one more stall -> StallCount=0xFFFF; Reset pulse between edges -> all outputs at reset values immediately.
